bnn_fc_argmax: RTL and testbench
================================

# bnn_fc_argmax

Parametrised binary fully-connected classifier stage for the BNN digit pipeline, placed after conv2 and before the class output port of `top`. It accepts a latched fan-in activation vector over a valid/ready handshake and evaluates every output node as XNOR-popcount over P-bit chunks plus a signed per-node offset. It tracks the running argmax and presents the winning class under valid/ready. Weights and offsets are loaded through dedicated write ports, replacing the image-bit-packed load path.

## Interface
- FAN_IN, 960, activation/weight bits per node; must be a multiple of P
- N_OUT, 10, output nodes (classes), ≥2
- P, 64, bits processed per cycle; NCHUNK = FAN_IN/P
- OW, 9, signed offset width
- SW, 17, signed score width; must hold FAN_IN + 2^(OW-1)−1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- act_in_valid  in  1  activation vector valid
- act_in_ready  out  1  high only in IDLE
- act_in  in  FAN_IN  activation bits; bit i belongs to chunk i/P
- w_wr_en  in  1  weight chunk write strobe
- w_wr_node  in  $clog2(N_OUT)  target node
- w_wr_chunk  in  $clog2(NCHUNK)  target chunk
- w_wr_data  in  P  weight bits
- off_wr_en  in  1  offset write strobe
- off_wr_node  in  $clog2(N_OUT)  target node
- off_wr_data  in  OW  signed offset
- class_out_valid  out  1  result valid
- class_out_ready  in  1  consumer accepts result
- class_out  out  $clog2(N_OUT)  winning node index
- max_score_out  out  SW  signed score of the winner
- busy  out  1  state ≠ IDLE
- cfg_err  out  1  sticky; a write was dropped while busy

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: act_in_valid & act_in_ready latches act_in, clears node/chunk counters and acc, sets best_score to the most negative value and best_idx to 0, then → ACCUM.
- ACCUM: each cycle acc_next = acc + popcount(~(act[c] ^ W[n][c])) for the current node n and chunk c.
  - c wraps at NCHUNK−1. On wrap, score = acc_next + sext(offset[n]), signed.
  - If score > best_score (strict), best is updated, so ties keep the lowest index.
  - acc clears and n increments.
  - On wrap with n = N_OUT−1 → DONE.
- DONE: class_out_valid=1, and class_out/max_score_out hold best_idx/best_score. On class_out_ready → IDLE.
- Writes (weights or offsets) take effect only in IDLE. In ACCUM or DONE they are dropped and cfg_err is set. cfg_err clears only on reset.
- A simultaneous weight write and act_in handshake in IDLE: the write commits, and the new computation uses the updated value.
- Out-of-range node/chunk write addresses are dropped and set cfg_err.
- Arithmetic: popcount is $clog2(P+1) bits and zero-extended. acc is SW bits. Offsets are sign-extended to SW. No saturation is needed given the SW constraint.

## Timing
- Reset (async, any state): state=IDLE, act_in_ready=1, class_out_valid=0, class_out=0, max_score_out=0, busy=0, cfg_err=0, offsets=0. The weight array is not reset.
- Acceptance at edge 0. ACCUM runs edges 1..N_OUT·NCHUNK. class_out_valid is high after edge N_OUT·NCHUNK+1; with defaults that is 151.
- Outputs are registered and stable while class_out_valid & !class_out_ready.
- Handshake at edge k → IDLE after k. act_in_ready is high after k, so there is a minimum one-cycle bubble between results.
- Reset mid-ACCUM aborts the computation, and no result is produced.

## Configuration
- BNN_FC_SCORES_EN defined:
  - Adds output score_out [N_OUT·SW], node n at bits [n·SW +: SW].
  - Each node's score is registered at its final chunk and held until the next acceptance. Reset value is 0.
- BNN_FC_SCORES_EN undefined: the port and its registers are absent, and only max_score_out is available.

## Test plan
- Defaults, all weights 0, all offsets 0, act all 0 → every score 960; class_out=0, max_score_out=960; valid first seen after edge 151.
- Same as above with offset[7]=+5 and offset[2]=+5 → class_out=2 (tie, lowest index), max_score_out=965. With BNN_FC_SCORES_EN, score_out node 7 = 965 and node 0 = 960.
- act all 1, node 4 weights all 1, other weights 0, offsets −128 → scores −128 except node 4 = 832; class_out=4.
- Hold class_out_ready low for 20 cycles after valid → outputs constant, act_in_ready=0, busy=1. Raise ready → busy=0 the next cycle.
- Weight and offset writes during ACCUM → cfg_err=1, result identical to the no-write run, writes not applied afterwards.
- Assert rst_n low at ACCUM cycle 40 → immediate reset values. Re-issue the first case → class_out=0, score 960 with full latency.

Source files
------------

// File: rtl/bnn_fc_argmax_if.sv
// ---------------------------------------------------------------------------
// bnn_fc_argmax_if
// Bundles every non-clock signal of the binary fully-connected argmax stage.
//   Activation input : act_in_valid, act_in_ready, act_in[FAN_IN]
//   Weight writes    : w_wr_en, w_wr_node, w_wr_chunk, w_wr_data[P]
//   Offset writes    : off_wr_en, off_wr_node, off_wr_data[OW] (signed)
//   Result output    : class_out_valid, class_out_ready, class_out,
//                      max_score_out[SW] (signed)
//   Status           : busy, cfg_err
//   Optional         : score_out[N_OUT*SW], present when BNN_FC_SCORES_EN
//                      is defined (node n at bits [n*SW +: SW])
// Modports: master = producer/consumer side, slave = the classifier.
// ---------------------------------------------------------------------------
interface bnn_fc_argmax_if #(
    parameter int FAN_IN = 960,
    parameter int N_OUT  = 10,
    parameter int P      = 64,
    parameter int OW     = 9,
    parameter int SW     = 17
);
    localparam int NCHUNK = FAN_IN / P;
    localparam int NW     = (N_OUT  > 1) ? $clog2(N_OUT)  : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic                   act_in_valid;
    logic                   act_in_ready;
    logic [FAN_IN-1:0]      act_in;

    logic                   w_wr_en;
    logic [NW-1:0]          w_wr_node;
    logic [CW-1:0]          w_wr_chunk;
    logic [P-1:0]           w_wr_data;

    logic                   off_wr_en;
    logic [NW-1:0]          off_wr_node;
    logic signed [OW-1:0]   off_wr_data;

    logic                   class_out_valid;
    logic                   class_out_ready;
    logic [NW-1:0]          class_out;
    logic signed [SW-1:0]   max_score_out;

    logic                   busy;
    logic                   cfg_err;
`ifdef BNN_FC_SCORES_EN
    logic [N_OUT*SW-1:0]    score_out;
`endif

    modport master (
        output act_in_valid, act_in,
        output w_wr_en, w_wr_node, w_wr_chunk, w_wr_data,
        output off_wr_en, off_wr_node, off_wr_data,
        output class_out_ready,
        input  act_in_ready, class_out_valid, class_out, max_score_out,
        input  busy, cfg_err
`ifdef BNN_FC_SCORES_EN
        , input score_out
`endif
    );

    modport slave (
        input  act_in_valid, act_in,
        input  w_wr_en, w_wr_node, w_wr_chunk, w_wr_data,
        input  off_wr_en, off_wr_node, off_wr_data,
        input  class_out_ready,
        output act_in_ready, class_out_valid, class_out, max_score_out,
        output busy, cfg_err
`ifdef BNN_FC_SCORES_EN
        , output score_out
`endif
    );
endinterface

// File: rtl/bnn_fc_argmax.sv
// ---------------------------------------------------------------------------
// bnn_fc_argmax
// Binary fully-connected classifier with running argmax. A latched FAN_IN-bit
// activation vector is scored against every node as XNOR-popcount over P-bit
// chunks (one chunk per clock) plus a signed per-node offset; the highest
// score (lowest index on ties) is presented under valid/ready.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_if   : bnn_fc_argmax_if.slave (activation in, weight/offset writes,
//             class result out, busy, sticky cfg_err)
// Optional feature macro: BNN_FC_SCORES_EN adds io_if.score_out with every
// node's final score, registered at that node's last chunk.
// ---------------------------------------------------------------------------
module bnn_fc_argmax #(
    parameter int FAN_IN = 960,
    parameter int N_OUT  = 10,
    parameter int P      = 64,
    parameter int OW     = 9,
    parameter int SW     = 17
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    bnn_fc_argmax_if.slave      io_if
);
    localparam int NCHUNK = FAN_IN / P;
    localparam int NW     = (N_OUT  > 1) ? $clog2(N_OUT)  : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PCW    = $clog2(P + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [FAN_IN-1:0]      r_act;
    logic [NW-1:0]          r_node;
    logic [CW-1:0]          r_chunk;
    logic signed [SW-1:0]   r_acc;
    logic signed [SW-1:0]   r_best_score;
    logic [NW-1:0]          r_best_idx;
    logic                   r_valid;
    logic [NW-1:0]          r_out_cls;
    logic signed [SW-1:0]   r_out_score;
    logic                   r_cfg_err;

    // Weight store: no reset, combinational read so the chunk fetched is the
    // one addressed by the current counters in the same cycle.
    logic [P-1:0]           r_w_mem [N_OUT][NCHUNK];
    logic signed [OW-1:0]   r_off   [N_OUT];

    logic                   w_accept;
    logic                   w_w_addr_ok;
    logic                   w_off_addr_ok;
    logic                   w_w_commit;
    logic                   w_off_commit;
    logic                   w_drop;
    logic [P-1:0]           w_act_chunk;
    logic [P-1:0]           w_weight;
    logic [PCW-1:0]         w_pop;
    logic signed [SW-1:0]   w_acc_next;
    logic signed [OW-1:0]   w_off_cur;
    logic signed [SW-1:0]   w_score;
    logic                   w_last_chunk;
    logic                   w_last_node;
    logic                   w_better;

    function automatic logic [PCW-1:0] popcount(input logic [P-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < P; k++) begin
            cnt = cnt + PCW'(v[k]);
        end
        return cnt;
    endfunction

    // ---------------- write port qualification ----------------
    assign w_accept      = (r_state == IDLE) && io_if.act_in_valid;
    assign w_w_addr_ok   = (int'(io_if.w_wr_node) < N_OUT) && (int'(io_if.w_wr_chunk) < NCHUNK);
    assign w_off_addr_ok = (int'(io_if.off_wr_node) < N_OUT);
    assign w_w_commit    = io_if.w_wr_en   && (r_state == IDLE) && w_w_addr_ok;
    assign w_off_commit  = io_if.off_wr_en && (r_state == IDLE) && w_off_addr_ok;
    assign w_drop        = (io_if.w_wr_en && !w_w_commit) || (io_if.off_wr_en && !w_off_commit);

    always_ff @(posedge i_clk) begin
        if (w_w_commit) begin
            r_w_mem[io_if.w_wr_node][io_if.w_wr_chunk] <= io_if.w_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < N_OUT; n++) begin
                r_off[n] <= '0;
            end
        end else if (w_off_commit) begin
            r_off[io_if.off_wr_node] <= io_if.off_wr_data;
        end
    end

    // ---------------- datapath ----------------
    assign w_act_chunk  = r_act[int'(r_chunk)*P +: P];
    assign w_weight     = r_w_mem[r_node][r_chunk];
    assign w_pop        = popcount(~(w_act_chunk ^ w_weight));
    assign w_acc_next   = r_acc + $signed({{(SW-PCW){1'b0}}, w_pop});
    assign w_off_cur    = r_off[r_node];
    assign w_score      = w_acc_next + $signed({{(SW-OW){w_off_cur[OW-1]}}, w_off_cur});
    assign w_last_chunk = (r_chunk == CW'(NCHUNK - 1));
    assign w_last_node  = (r_node == NW'(N_OUT - 1));
    // Strict compare: an equal later score never displaces an earlier node.
    assign w_better     = (w_score > r_best_score);

    // ---------------- FSM ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (io_if.act_in_valid) w_state_next = ACCUM;
            ACCUM:   if (w_last_chunk && w_last_node) w_state_next = DONE;
            DONE:    if (r_valid && io_if.class_out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_act        <= '0;
            r_node       <= '0;
            r_chunk      <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_valid      <= 1'b0;
            r_out_cls    <= '0;
            r_out_score  <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_drop) begin
                r_cfg_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_act        <= io_if.act_in;
                        r_node       <= '0;
                        r_chunk      <= '0;
                        r_acc        <= '0;
                        r_best_score <= {1'b1, {(SW-1){1'b0}}};
                        r_best_idx   <= '0;
                    end
                end
                ACCUM: begin
                    if (w_last_chunk) begin
                        r_chunk <= '0;
                        r_acc   <= '0;
                        r_node  <= r_node + 1'b1;
                        if (w_better) begin
                            r_best_score <= w_score;
                            r_best_idx   <= r_node;
                        end
                    end else begin
                        r_chunk <= r_chunk + 1'b1;
                        r_acc   <= w_acc_next;
                    end
                end
                DONE: begin
                    // The winner is copied into dedicated output registers one
                    // edge after the final node, so the result is stable for
                    // as long as the consumer stalls.
                    if (!r_valid) begin
                        r_valid     <= 1'b1;
                        r_out_cls   <= r_best_idx;
                        r_out_score <= r_best_score;
                    end else if (io_if.class_out_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_if.act_in_ready    = (r_state == IDLE);
    assign io_if.busy            = (r_state != IDLE);
    assign io_if.class_out_valid = r_valid;
    assign io_if.class_out       = r_out_cls;
    assign io_if.max_score_out   = r_out_score;
    assign io_if.cfg_err         = r_cfg_err;

`ifdef BNN_FC_SCORES_EN
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_score
        logic signed [SW-1:0] r_score;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_score <= '0;
            end else if ((r_state == ACCUM) && w_last_chunk && (r_node == NW'(gi))) begin
                r_score <= w_score;
            end
        end
        assign io_if.score_out[gi*SW +: SW] = r_score;
    end
`endif

endmodule

// File: tb/tb_bnn_fc_argmax.sv
module tb_bnn_fc_argmax;
    localparam int FAN_IN = 960;
    localparam int N_OUT  = 10;
    localparam int P      = 64;
    localparam int OW     = 9;
    localparam int SW     = 17;
    localparam int NCHUNK = FAN_IN / P;
    localparam int NW     = $clog2(N_OUT);
    localparam int CW     = $clog2(NCHUNK);
    localparam int LAT    = N_OUT * NCHUNK + 1;

    typedef struct {
        int                  cls;
        int                  score;
        logic [N_OUT*SW-1:0] sv;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   accept_cyc;
    logic prev_valid;
    exp_t sb[$];

    bnn_fc_argmax_if #(.FAN_IN(FAN_IN), .N_OUT(N_OUT), .P(P), .OW(OW), .SW(SW)) bus ();

    bnn_fc_argmax #(.FAN_IN(FAN_IN), .N_OUT(N_OUT), .P(P), .OW(OW), .SW(SW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        prev_valid = 1'b0;
        accept_cyc = 0;
    end

    always @(negedge clk) begin
        if (rst_n && bus.act_in_valid && bus.act_in_ready) begin
            accept_cyc = cyc + 1;
        end
        if (rst_n && bus.class_out_valid && !prev_valid) begin
            chk("latency", longint'(cyc - accept_cyc), longint'(LAT));
        end
        if (rst_n && bus.class_out_valid && bus.class_out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result: class_out=%0d max_score_out=%0d (want %0d/%0d)",
                         bus.class_out, $signed(bus.max_score_out), e.cls, e.score);
                chk("class_out", longint'(bus.class_out), longint'(e.cls));
                chk("max_score_out", longint'($signed(bus.max_score_out)), longint'(e.score));
`ifdef BNN_FC_SCORES_EN
                for (int n = 0; n < N_OUT; n++) begin
                    chk($sformatf("score_out[%0d]", n),
                        longint'($signed(bus.score_out[n*SW +: SW])),
                        longint'($signed(e.sv[n*SW +: SW])));
                end
`endif
            end
        end
        prev_valid = bus.class_out_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_OUT*SW-1:0] fill(input int v);
        logic [N_OUT*SW-1:0] r;
        for (int n = 0; n < N_OUT; n++) r[n*SW +: SW] = SW'(v);
        return r;
    endfunction

    task automatic write_w(input int n, input int c, input logic [P-1:0] d);
        bus.w_wr_en    = 1'b1;
        bus.w_wr_node  = NW'(n);
        bus.w_wr_chunk = CW'(c);
        bus.w_wr_data  = d;
        tick();
        bus.w_wr_en    = 1'b0;
    endtask

    task automatic write_off(input int n, input int v);
        bus.off_wr_en   = 1'b1;
        bus.off_wr_node = NW'(n);
        bus.off_wr_data = OW'(v);
        tick();
        bus.off_wr_en   = 1'b0;
    endtask

    task automatic zero_weights();
        for (int n = 0; n < N_OUT; n++)
            for (int c = 0; c < NCHUNK; c++)
                write_w(n, c, '0);
    endtask

    task automatic start(input logic [FAN_IN-1:0] a, input int cls, input int sc,
                         input logic [N_OUT*SW-1:0] sv);
        exp_t e;
        e.cls = cls; e.score = sc; e.sv = sv;
        sb.push_back(e);
        $display("issue: expect class %0d score %0d", cls, sc);
        bus.act_in       = a;
        bus.act_in_valid = 1'b1;
        tick();
        bus.act_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!bus.busy) return;
        end
        chk("timeout_idle", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [FAN_IN-1:0]   act_zero;
    logic [FAN_IN-1:0]   act_ones;
    logic [N_OUT*SW-1:0] sv;
    logic [P-1:0]        ones_p;
    bit                  seen;

    initial begin
        checks = 0; errors = 0;
        act_zero = '0; act_ones = '1; ones_p = '1;
        rst_n = 1'b0;
        bus.act_in_valid = 1'b0; bus.act_in = '0;
        bus.w_wr_en = 1'b0; bus.w_wr_node = '0; bus.w_wr_chunk = '0; bus.w_wr_data = '0;
        bus.off_wr_en = 1'b0; bus.off_wr_node = '0; bus.off_wr_data = '0;
        bus.class_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_act_in_ready", longint'(bus.act_in_ready), 1);
        chk("rst_valid", longint'(bus.class_out_valid), 0);
        chk("rst_class_out", longint'(bus.class_out), 0);
        chk("rst_max_score", longint'($signed(bus.max_score_out)), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_cfg_err", longint'(bus.cfg_err), 0);
        rst_n = 1'b1;
        tick();

        // Case 1: all zero -> every score 960, class 0
        zero_weights();
        start(act_zero, 0, 960, fill(960));
        wait_idle();

        // Case 2: offsets +5 on nodes 7 and 2 -> tie, lowest index wins
        write_off(7, 5);
        write_off(2, 5);
        sv = fill(960); sv[2*SW +: SW] = SW'(965); sv[7*SW +: SW] = SW'(965);
        start(act_zero, 2, 965, sv);
        wait_idle();

        // Case 3: node 4 all-ones weights, act all ones, offsets -128
        for (int c = 0; c < NCHUNK; c++) write_w(4, c, ones_p);
        for (int n = 0; n < N_OUT; n++) write_off(n, -128);
        sv = fill(-128); sv[4*SW +: SW] = SW'(832);
        bus.class_out_ready = 1'b0;
        start(act_ones, 4, 832, sv);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (bus.class_out_valid) seen = 1'b1;
        end
        if (!seen) chk("timeout_valid", 1, 0);
        for (int i = 0; i < 20; i++) begin
            chk("hold_valid", longint'(bus.class_out_valid), 1);
            chk("hold_class", longint'(bus.class_out), 4);
            chk("hold_score", longint'($signed(bus.max_score_out)), 832);
            chk("hold_act_in_ready", longint'(bus.act_in_ready), 0);
            chk("hold_busy", longint'(bus.busy), 1);
            tick();
        end
        bus.class_out_ready = 1'b1;
        tick();
        chk("release_busy", longint'(bus.busy), 0);
        chk("release_act_in_ready", longint'(bus.act_in_ready), 1);

        // Writes while busy are dropped and flag cfg_err
        chk("cfg_err_before", longint'(bus.cfg_err), 0);
        start(act_ones, 4, 832, sv);
        repeat (5) tick();
        write_w(4, 0, '0);
        write_off(1, 200);
        wait_idle();
        chk("cfg_err_after", longint'(bus.cfg_err), 1);
        start(act_ones, 4, 832, sv);
        wait_idle();

        // Reset in the middle of ACCUM: no result, immediate reset values
        start(act_ones, 4, 832, sv);
        repeat (40) tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("mid_rst_act_in_ready", longint'(bus.act_in_ready), 1);
        chk("mid_rst_valid", longint'(bus.class_out_valid), 0);
        chk("mid_rst_class_out", longint'(bus.class_out), 0);
        chk("mid_rst_max_score", longint'($signed(bus.max_score_out)), 0);
        chk("mid_rst_busy", longint'(bus.busy), 0);
        chk("mid_rst_cfg_err", longint'(bus.cfg_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Re-issue case 1 (offsets back to 0 from reset)
        zero_weights();
        start(act_zero, 0, 960, fill(960));
        wait_idle();

        // Weight write in the same cycle as acceptance is used by that run
        bus.w_wr_en = 1'b1; bus.w_wr_node = '0; bus.w_wr_chunk = '0; bus.w_wr_data = ones_p;
        sv = fill(960); sv[0 +: SW] = SW'(896);
        start(act_zero, 1, 960, sv);
        bus.w_wr_en = 1'b0;
        wait_idle();

        // Out-of-range address while idle
        chk("cfg_err_clean", longint'(bus.cfg_err), 0);
        write_w(10, 0, '0);
        chk("cfg_err_oor", longint'(bus.cfg_err), 1);
        chk("sb_empty", longint'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
